// File: rtl/axi_rr_arbiter.sv
// Two-master AXI4 arbiter: round-robin, whole-transaction grants.
// Ports: i_clock/i_reset; upstream masters 0 (ifetch) and 1 (LSU)
// on i_axi_*n/o_axi_*n; downstream port on unsuffixed o_axi_*/i_axi_*;
// o_rgrant/o_wgrant one-hot {m1,m0}; o_busy = any grant held.
module axi_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    // master 0 AR / R
    input  logic [ADDR_W-1:0] i_axi_araddr0,
    input  logic              i_axi_arvalid0,
    input  logic [3:0]        i_axi_arid0,
    input  logic [7:0]        i_axi_arlen0,
    input  logic [2:0]        i_axi_arsize0,
    input  logic [1:0]        i_axi_arburst0,
    output logic              o_axi_arready0,
    output logic [DATA_W-1:0] o_axi_rdata0,
    output logic              o_axi_rvalid0,
    output logic [1:0]        o_axi_rresp0,
    output logic [3:0]        o_axi_rid0,
    output logic              o_axi_rlast0,
    input  logic              i_axi_rready0,
    // master 1 AR / R
    input  logic [ADDR_W-1:0] i_axi_araddr1,
    input  logic              i_axi_arvalid1,
    input  logic [3:0]        i_axi_arid1,
    input  logic [7:0]        i_axi_arlen1,
    input  logic [2:0]        i_axi_arsize1,
    input  logic [1:0]        i_axi_arburst1,
    output logic              o_axi_arready1,
    output logic [DATA_W-1:0] o_axi_rdata1,
    output logic              o_axi_rvalid1,
    output logic [1:0]        o_axi_rresp1,
    output logic [3:0]        o_axi_rid1,
    output logic              o_axi_rlast1,
    input  logic              i_axi_rready1,
    // master 0 AW / W / B
    input  logic [ADDR_W-1:0] i_axi_awaddr0,
    input  logic              i_axi_awvalid0,
    input  logic [3:0]        i_axi_awid0,
    input  logic [7:0]        i_axi_awlen0,
    input  logic [2:0]        i_axi_awsize0,
    input  logic [1:0]        i_axi_awburst0,
    output logic              o_axi_awready0,
    input  logic [DATA_W-1:0] i_axi_wdata0,
    input  logic [DATA_W/8-1:0] i_axi_wstrb0,
    input  logic              i_axi_wvalid0,
    input  logic              i_axi_wlast0,
    output logic              o_axi_wready0,
    output logic [1:0]        o_axi_bresp0,
    output logic              o_axi_bvalid0,
    output logic [3:0]        o_axi_bid0,
    input  logic              i_axi_bready0,
    // master 1 AW / W / B
    input  logic [ADDR_W-1:0] i_axi_awaddr1,
    input  logic              i_axi_awvalid1,
    input  logic [3:0]        i_axi_awid1,
    input  logic [7:0]        i_axi_awlen1,
    input  logic [2:0]        i_axi_awsize1,
    input  logic [1:0]        i_axi_awburst1,
    output logic              o_axi_awready1,
    input  logic [DATA_W-1:0] i_axi_wdata1,
    input  logic [DATA_W/8-1:0] i_axi_wstrb1,
    input  logic              i_axi_wvalid1,
    input  logic              i_axi_wlast1,
    output logic              o_axi_wready1,
    output logic [1:0]        o_axi_bresp1,
    output logic              o_axi_bvalid1,
    output logic [3:0]        o_axi_bid1,
    input  logic              i_axi_bready1,
    // downstream
    output logic [ADDR_W-1:0] o_axi_araddr,
    output logic              o_axi_arvalid,
    output logic [3:0]        o_axi_arid,
    output logic [7:0]        o_axi_arlen,
    output logic [2:0]        o_axi_arsize,
    output logic [1:0]        o_axi_arburst,
    input  logic              i_axi_arready,
    input  logic [DATA_W-1:0] i_axi_rdata,
    input  logic              i_axi_rvalid,
    input  logic [1:0]        i_axi_rresp,
    input  logic [3:0]        i_axi_rid,
    input  logic              i_axi_rlast,
    output logic              o_axi_rready,
    output logic [ADDR_W-1:0] o_axi_awaddr,
    output logic              o_axi_awvalid,
    output logic [3:0]        o_axi_awid,
    output logic [7:0]        o_axi_awlen,
    output logic [2:0]        o_axi_awsize,
    output logic [1:0]        o_axi_awburst,
    input  logic              i_axi_awready,
    output logic [DATA_W-1:0] o_axi_wdata,
    output logic [DATA_W/8-1:0] o_axi_wstrb,
    output logic              o_axi_wvalid,
    output logic              o_axi_wlast,
    input  logic              i_axi_wready,
    input  logic [1:0]        i_axi_bresp,
    input  logic              i_axi_bvalid,
    input  logic [3:0]        i_axi_bid,
    output logic              o_axi_bready,
    // status
    output logic [1:0]        o_rgrant,
    output logic [1:0]        o_wgrant,
    output logic              o_busy
);

    localparam int SW = DATA_W / 8;

    typedef enum logic [1:0] {R_IDLE, R_GNT0, R_GNT1} r_state_e;
    typedef enum logic [1:0] {W_IDLE, W_GNT0, W_GNT1} w_state_e;

    r_state_e r_state_q, r_state_d;
    w_state_e w_state_q, w_state_d;
    logic     r_ptr_q, r_ptr_d, w_ptr_q, w_ptr_d;
    logic     ar_done_q, ar_done_d;
    logic     aw_done_q, aw_done_d;
    logic     w_done_q, w_done_d;
    logic     r_rel, w_rel;
    logic     rg0, rg1, wg0, wg1;

    // Tie goes to the master that was not served last.
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            r_ptr_q   <= 1'b1;
            w_ptr_q   <= 1'b1;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            r_ptr_q   <= r_ptr_d;
            w_ptr_q   <= w_ptr_d;
            ar_done_q <= ar_done_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        r_ptr_d   = r_ptr_q;
        ar_done_d = ar_done_q;
        r_rel     = 1'b0;
        unique case (r_state_q)
            R_GNT0, R_GNT1: begin
                if (o_axi_arvalid && i_axi_arready)
                    ar_done_d = 1'b1;
                r_rel = i_axi_rvalid && o_axi_rready && i_axi_rlast;
            end
            default: ;
        endcase
        // Release and idle share one pick, giving bubble-free handoff.
        if (r_state_q == R_IDLE || r_rel) begin
            ar_done_d = 1'b0;
            r_state_d = R_IDLE;
            if (i_axi_arvalid0 || i_axi_arvalid1) begin
                r_ptr_d   = rr_pick(i_axi_arvalid0, i_axi_arvalid1, r_ptr_q);
                r_state_d = r_ptr_d ? R_GNT1 : R_GNT0;
            end
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        w_ptr_d   = w_ptr_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        w_rel     = 1'b0;
        unique case (w_state_q)
            W_GNT0, W_GNT1: begin
                if (o_axi_awvalid && i_axi_awready)
                    aw_done_d = 1'b1;
                if (o_axi_wvalid && i_axi_wready && o_axi_wlast)
                    w_done_d = 1'b1;
                w_rel = i_axi_bvalid && o_axi_bready;
            end
            default: ;
        endcase
        if (w_state_q == W_IDLE || w_rel) begin
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            w_state_d = W_IDLE;
            if (i_axi_awvalid0 || i_axi_awvalid1) begin
                w_ptr_d   = rr_pick(i_axi_awvalid0, i_axi_awvalid1, w_ptr_q);
                w_state_d = w_ptr_d ? W_GNT1 : W_GNT0;
            end
        end
    end

    assign rg0 = (r_state_q == R_GNT0);
    assign rg1 = (r_state_q == R_GNT1);
    assign wg0 = (w_state_q == W_GNT0);
    assign wg1 = (w_state_q == W_GNT1);

    assign o_rgrant = {rg1, rg0};
    assign o_wgrant = {wg1, wg0};
    assign o_busy   = rg0 | rg1 | wg0 | wg1;

    // AND-OR muxing: grants are one-hot, so idle yields all zeros.
    assign o_axi_araddr  = ({ADDR_W{rg0}} & i_axi_araddr0)
                         | ({ADDR_W{rg1}} & i_axi_araddr1);
    assign o_axi_arid    = ({4{rg0}} & i_axi_arid0) | ({4{rg1}} & i_axi_arid1);
    assign o_axi_arlen   = ({8{rg0}} & i_axi_arlen0) | ({8{rg1}} & i_axi_arlen1);
    assign o_axi_arsize  = ({3{rg0}} & i_axi_arsize0)
                         | ({3{rg1}} & i_axi_arsize1);
    assign o_axi_arburst = ({2{rg0}} & i_axi_arburst0)
                         | ({2{rg1}} & i_axi_arburst1);
    assign o_axi_arvalid = ~ar_done_q
                         & ((rg0 & i_axi_arvalid0) | (rg1 & i_axi_arvalid1));
    assign o_axi_rready  = (rg0 & i_axi_rready0) | (rg1 & i_axi_rready1);

    assign o_axi_arready0 = rg0 & ~ar_done_q & i_axi_arready;
    assign o_axi_arready1 = rg1 & ~ar_done_q & i_axi_arready;
    assign o_axi_rvalid0  = rg0 & i_axi_rvalid;
    assign o_axi_rvalid1  = rg1 & i_axi_rvalid;
    assign o_axi_rdata0   = {DATA_W{rg0}} & i_axi_rdata;
    assign o_axi_rdata1   = {DATA_W{rg1}} & i_axi_rdata;
    assign o_axi_rresp0   = {2{rg0}} & i_axi_rresp;
    assign o_axi_rresp1   = {2{rg1}} & i_axi_rresp;
    assign o_axi_rid0     = {4{rg0}} & i_axi_rid;
    assign o_axi_rid1     = {4{rg1}} & i_axi_rid;
    assign o_axi_rlast0   = rg0 & i_axi_rlast;
    assign o_axi_rlast1   = rg1 & i_axi_rlast;

    assign o_axi_awaddr  = ({ADDR_W{wg0}} & i_axi_awaddr0)
                         | ({ADDR_W{wg1}} & i_axi_awaddr1);
    assign o_axi_awid    = ({4{wg0}} & i_axi_awid0) | ({4{wg1}} & i_axi_awid1);
    assign o_axi_awlen   = ({8{wg0}} & i_axi_awlen0) | ({8{wg1}} & i_axi_awlen1);
    assign o_axi_awsize  = ({3{wg0}} & i_axi_awsize0)
                         | ({3{wg1}} & i_axi_awsize1);
    assign o_axi_awburst = ({2{wg0}} & i_axi_awburst0)
                         | ({2{wg1}} & i_axi_awburst1);
    assign o_axi_awvalid = ~aw_done_q
                         & ((wg0 & i_axi_awvalid0) | (wg1 & i_axi_awvalid1));
    assign o_axi_wdata   = ({DATA_W{wg0}} & i_axi_wdata0)
                         | ({DATA_W{wg1}} & i_axi_wdata1);
    assign o_axi_wstrb   = ({SW{wg0}} & i_axi_wstrb0) | ({SW{wg1}} & i_axi_wstrb1);
    assign o_axi_wlast   = (wg0 & i_axi_wlast0) | (wg1 & i_axi_wlast1);
    assign o_axi_wvalid  = ~w_done_q
                         & ((wg0 & i_axi_wvalid0) | (wg1 & i_axi_wvalid1));
    assign o_axi_bready  = (wg0 & i_axi_bready0) | (wg1 & i_axi_bready1);

    assign o_axi_awready0 = wg0 & ~aw_done_q & i_axi_awready;
    assign o_axi_awready1 = wg1 & ~aw_done_q & i_axi_awready;
    assign o_axi_wready0  = wg0 & ~w_done_q & i_axi_wready;
    assign o_axi_wready1  = wg1 & ~w_done_q & i_axi_wready;
    assign o_axi_bvalid0  = wg0 & i_axi_bvalid;
    assign o_axi_bvalid1  = wg1 & i_axi_bvalid;
    assign o_axi_bresp0   = {2{wg0}} & i_axi_bresp;
    assign o_axi_bresp1   = {2{wg1}} & i_axi_bresp;
    assign o_axi_bid0     = {4{wg0}} & i_axi_bid;
    assign o_axi_bid1     = {4{wg1}} & i_axi_bid;

endmodule
